// File: rtl/mux_nway_rr_reg_pkg.sv
// Shared definitions for the N-way registered selector: select-mode encodings and a
// constant-evaluable ceil(log2) used to size channel indices.
package mux_nway_rr_reg_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_nway_rr_reg_rr_arbiter.sv
// Round-robin arbiter: rotates the request vector so ptr_i lands at bit 0, picks the lowest
// set bit, then rotates the one-hot result back into channel order.
module mux_nway_rr_reg_rr_arbiter
   import mux_nway_rr_reg_pkg::*;
#(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned PTRW   = clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req_i,
   input  logic [PTRW-1:0]   ptr_i,
   output logic [NUM_IN-1:0] grant_o
);

   logic [2*NUM_IN-1:0] req_dbl;
   logic [2*NUM_IN-1:0] gnt_dbl;
   logic [NUM_IN-1:0]   req_rot;
   logic [NUM_IN-1:0]   gnt_rot;
   logic                found;

   always_comb begin
      req_dbl = {req_i, req_i};
      req_rot = NUM_IN'(req_dbl >> ptr_i);
      gnt_rot = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (!found && req_rot[k]) begin
            gnt_rot[k] = 1'b1;
            found      = 1'b1;
         end
      end
      // Undo the rotation; the two halves fold a wrapped grant back below NUM_IN.
      gnt_dbl = {{NUM_IN{1'b0}}, gnt_rot} << ptr_i;
      grant_o = gnt_dbl[NUM_IN-1:0] | gnt_dbl[2*NUM_IN-1:NUM_IN];
   end

endmodule

// File: rtl/mux_nway_rr_reg.sv
// Registered N-channel selector with valid/ready handshake. Explicit (sel) or round-robin
// channel choice, one output register stage, rr pointer tracks the last transfer in both modes.
module mux_nway_rr_reg
   import mux_nway_rr_reg_pkg::*;
#(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SELW   = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SELW-1:0]         sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SELW-1:0]         out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [NUM_IN-1:0] rr_gnt;
   logic [NUM_IN-1:0] fix_gnt;
   logic [NUM_IN-1:0] grant;
   logic              load;
   logic              xfer;
   logic [WIDTH-1:0]  gnt_data;
   logic [SELW-1:0]   gnt_idx;

   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SELW-1:0]   out_sel_q,   out_sel_d;
   logic              out_valid_q, out_valid_d;
   logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

   mux_nway_rr_reg_rr_arbiter #(
      .NUM_IN (NUM_IN),
      .PTRW   (SELW)
   ) u_arb (
      .req_i   (in_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (rr_gnt)
   );

   // Grant selection, handshake and next-state for the output stage and rr pointer.
   always_comb begin
      fix_gnt = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         fix_gnt[i] = in_valid[i] && (sel == SELW'(i));
      end

      grant    = (mode == MODE_RR) ? rr_gnt : fix_gnt;
      load     = !out_valid_q || out_ready;
      in_ready = grant & {NUM_IN{load}};
      xfer     = |in_ready;

      gnt_data = '0;
      gnt_idx  = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (grant[i]) begin
            gnt_data = in_data[i*WIDTH +: WIDTH];
            gnt_idx  = SELW'(i);
         end
      end

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = gnt_data;
            out_sel_d  = gnt_idx;
         end
      end
      if (xfer) begin
         rr_ptr_d = (gnt_idx == SELW'(NUM_IN - 1)) ? '0 : gnt_idx + SELW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule
